// File: rtl/dmem_port_pkg.sv
// rtl/dmem_port_pkg.sv - shared constants and FSM encoding for the data-memory port
package dmem_port_pkg;

    localparam int WORD_WIDTH    = 32;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR_REQ  = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_port_sbuf.sv
// rtl/dmem_port_sbuf.sv - posted store FIFO with youngest-match load lookup
module dmem_port_sbuf
    import dmem_port_pkg::*;
#(
    parameter int W     = WORD_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_addr,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic [W-1:0]  look_addr,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head_addr,
    output logic [W-1:0]  head_data,
    output logic          hit,
    output logic [W-1:0]  hit_data
);

    logic [W-1:0]  addr_mem [DEPTH];
    logic [W-1:0]  data_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= push_addr;
            data_mem[tail] <= push_data;
        end
    end

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];

    // Walk oldest to youngest so the last match found is the youngest store.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (addr_mem[idx] == look_addr)) begin
                hit      = 1'b1;
                hit_data = data_mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_port.sv
// rtl/dmem_port.sv - CPU load/store responder with posted store buffer and backing-memory port
module dmem_port
    import dmem_port_pkg::*;
#(
    parameter int W     = WORD_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_en,
    input  logic [W-1:0] l_addr,
    output logic [W-1:0] l_data,
    input  logic         store_en,
    input  logic [W-1:0] s_addr,
    input  logic [W-1:0] s_data,
    output logic         stall,
    output logic         req_valid,
    input  logic         req_ready,
    output logic         req_we,
    output logic [W-1:0] req_addr,
    output logic [W-1:0] req_wdata,
    input  logic         rsp_valid,
    input  logic [W-1:0] rsp_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [W-1:0] ALIGN_MASK = ~W'(3);

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  rd_addr;
    logic [CW-1:0] count;
    logic [W-1:0]  head_addr;
    logic [W-1:0]  head_data;
    logic [W-1:0]  hit_data;
    logic          full;
    logic          empty;
    logic          hit;
    logic          load_req;
    logic          push;
    logic          pop;
    logic          miss;
    logic          rd_done;

    // A simultaneous store wins; the load is dropped for that cycle.
    assign load_req = load_en & ~store_en;
    assign push     = store_en & ~full;
    assign pop      = (state == WR_REQ) & req_ready;
    assign miss     = load_req & ~hit;
    assign rd_done  = (state == RD_WAIT) & rsp_valid;

    dmem_port_sbuf #(.W(W), .DEPTH(DEPTH)) u_sbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (s_addr & ALIGN_MASK),
        .push_data (s_data),
        .pop       (pop),
        .look_addr (l_addr & ALIGN_MASK),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head_addr (head_addr),
        .head_data (head_data),
        .hit       (hit),
        .hit_data  (hit_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_addr <= '0;
        end else begin
            state <= state_nxt;
            if ((state_nxt == RD_REQ) && (state != RD_REQ))
                rd_addr <= l_addr & ALIGN_MASK;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (miss)        state_nxt = RD_REQ;
                else if (!empty) state_nxt = WR_REQ;
            end
            RD_REQ:  if (req_ready) state_nxt = RD_WAIT;
            RD_WAIT: if (rsp_valid) state_nxt = IDLE;
            WR_REQ: begin
                if (req_ready) begin
                    if (miss)                 state_nxt = RD_REQ;
                    else if (count > CW'(1))  state_nxt = WR_REQ;
                    else                      state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields come straight from state and held sources, so they cannot change before req_ready.
    always_comb begin
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        case (state)
            RD_REQ: begin
                req_valid = 1'b1;
                req_addr  = rd_addr;
            end
            WR_REQ: begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = head_addr;
                req_wdata = head_data;
            end
            default: ;
        endcase
    end

    assign stall = (store_en & full) | (miss & ~rd_done);

    always_comb begin
        l_data = '0;
        if (load_req && hit)          l_data = hit_data;
        else if (load_req && rd_done) l_data = rsp_rdata;
    end

endmodule

// File: tb/tb_dmem_port.sv
// tb/tb_dmem_port.sv - scoreboard bench for dmem_port
module tb_dmem_port;

    logic        clk;
    logic        rst_n;
    logic        load_en;
    logic [31:0] l_addr;
    logic [31:0] l_data;
    logic        store_en;
    logic [31:0] s_addr;
    logic [31:0] s_data;
    logic        stall;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          rd_cnt = 0;
    int          rd_base;
    logic [63:0] wr_q [$];
    logic [31:0] ld_q [$];
    logic        held = 1'b0;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    logic        h_we;

    dmem_port dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .l_addr    (l_addr),
        .l_data    (l_data),
        .store_en  (store_en),
        .s_addr    (s_addr),
        .s_data    (s_data),
        .stall     (stall),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        store_en = 1'b1;
        s_addr   = a;
        s_data   = d;
        wr_q.push_back({a & ~32'd3, d});
        mid();
        check_eq("store_accept_stall", stall, 1'b0);
        nxt();
        store_en = 1'b0;
    endtask

    task automatic drain();
        req_ready = 1'b1;
        for (int i = 0; i < 40 && wr_q.size() > 0; i++) nxt();
        check_eq("drain_done", 32'(wr_q.size()), 32'd0);
        req_ready = 1'b0;
    endtask

    // Scoreboard side: writes and completing loads are popped as the DUT produces them.
    always @(negedge clk) begin
        logic [63:0] e;
        logic [31:0] le;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check_eq("hold_valid", req_valid, 1'b1);
                check_eq("hold_addr", req_addr, h_addr);
                check_eq("hold_we", req_we, h_we);
                check_eq("hold_wdata", req_wdata, h_wdata);
            end
            held    = req_valid & ~req_ready;
            h_addr  = req_addr;
            h_we    = req_we;
            h_wdata = req_wdata;
            if (req_valid && req_ready && req_we) begin
                e = (wr_q.size() > 0) ? wr_q.pop_front() : '1;
                check_eq("wr_addr", req_addr, e[63:32]);
                check_eq("wr_data", req_wdata, e[31:0]);
            end
            if (req_valid && req_ready && !req_we) rd_cnt++;
            if (load_en && !store_en && !stall) begin
                le = (ld_q.size() > 0) ? ld_q.pop_front() : 32'hDEAD_0000;
                check_eq("load_data", l_data, le);
            end else begin
                check_eq("ldata_idle", l_data, 32'd0);
            end
        end
    end

    initial begin
        rst_n = 1'b0; load_en = 1'b0; l_addr = '0; store_en = 1'b0; s_addr = '0; s_data = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
        mid();
        check_eq("rst_stall", stall, 1'b0);
        check_eq("rst_ldata", l_data, 32'd0);
        check_eq("rst_req_valid", req_valid, 1'b0);
        check_eq("rst_req_we", req_we, 1'b0);
        check_eq("rst_req_addr", req_addr, 32'd0);
        check_eq("rst_req_wdata", req_wdata, 32'd0);
        nxt();
        rst_n = 1'b1;
        nxt();

        // store then load hit on the next cycle
        rd_base = rd_cnt;
        do_store(32'h100, 32'hDEADBEEF);
        load_en = 1'b1; l_addr = 32'h100; ld_q.push_back(32'hDEADBEEF);
        mid();
        check_eq("hit_stall", stall, 1'b0);
        nxt();
        load_en = 1'b0;
        drain();
        check_eq("hit_no_read", 32'(rd_cnt), 32'(rd_base));

        // youngest of two matching entries, low address bits ignored
        do_store(32'h10, 32'h1);
        do_store(32'h10, 32'h2);
        load_en = 1'b1; l_addr = 32'h12; ld_q.push_back(32'h2);
        mid();
        check_eq("young_stall", stall, 1'b0);
        nxt();
        load_en = 1'b0;
        drain();

        // store and load together: store served, load ignored
        rd_base = rd_cnt;
        store_en = 1'b1; load_en = 1'b1; s_addr = 32'h700; l_addr = 32'h700; s_data = 32'h11;
        wr_q.push_back({32'h700, 32'h11});
        mid();
        check_eq("both_stall", stall, 1'b0);
        nxt();
        store_en = 1'b0;
        ld_q.push_back(32'h11);
        mid();
        check_eq("both_hit_stall", stall, 1'b0);
        nxt();
        load_en = 1'b0;
        drain();
        check_eq("both_no_read", 32'(rd_cnt), 32'(rd_base));

        // fill the buffer, fifth store waits for the first pop
        for (int i = 0; i < 4; i++) do_store(32'h40 + 32'(4 * i), 32'hA0 + 32'(i));
        store_en = 1'b1; s_addr = 32'h50; s_data = 32'hA4;
        wr_q.push_back({32'h50, 32'hA4});
        mid();
        check_eq("full_stall", stall, 1'b1);
        nxt();
        mid();
        check_eq("full_hold", stall, 1'b1);
        nxt();
        req_ready = 1'b1;
        mid();
        check_eq("full_pop_cycle", stall, 1'b1);
        nxt();
        mid();
        check_eq("full_admit", stall, 1'b0);
        nxt();
        store_en = 1'b0;
        drain();

        // load miss from idle, response two cycles after acceptance
        req_ready = 1'b1;
        load_en = 1'b1; l_addr = 32'h200; ld_q.push_back(32'hCAFEF00D);
        mid();
        check_eq("miss_c1_stall", stall, 1'b1);
        nxt();
        mid();
        check_eq("miss_req_valid", req_valid, 1'b1);
        check_eq("miss_req_we", req_we, 1'b0);
        check_eq("miss_req_addr", req_addr, 32'h200);
        check_eq("miss_c2_stall", stall, 1'b1);
        nxt();
        req_ready = 1'b0;
        mid();
        check_eq("miss_c3_stall", stall, 1'b1);
        check_eq("miss_wait_valid", req_valid, 1'b0);
        nxt();
        rsp_valid = 1'b1; rsp_rdata = 32'hCAFEF00D;
        mid();
        check_eq("miss_done_stall", stall, 1'b0);
        nxt();
        rsp_valid = 1'b0; load_en = 1'b0;

        // load miss behind a held write
        do_store(32'h300, 32'h55);
        nxt();
        load_en = 1'b1; l_addr = 32'h400; ld_q.push_back(32'h77);
        for (int i = 0; i < 3; i++) begin
            mid();
            check_eq("wrhold_stall", stall, 1'b1);
            check_eq("wrhold_we", req_we, 1'b1);
            check_eq("wrhold_addr", req_addr, 32'h300);
            nxt();
        end
        req_ready = 1'b1;
        mid();
        check_eq("wrhold_hs_we", req_we, 1'b1);
        nxt();
        mid();
        check_eq("after_wr_rd_we", req_we, 1'b0);
        check_eq("after_wr_rd_addr", req_addr, 32'h400);
        check_eq("after_wr_q", 32'(wr_q.size()), 32'd0);
        nxt();
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'h77;
        mid();
        check_eq("after_wr_done", stall, 1'b0);
        nxt();
        rsp_valid = 1'b0; load_en = 1'b0;

        // reset during RD_WAIT with two entries still buffered
        do_store(32'h500, 32'h1);
        do_store(32'h504, 32'h2);
        do_store(32'h508, 32'h3);
        load_en = 1'b1; l_addr = 32'h600;
        mid();
        check_eq("rstt_stall", stall, 1'b1);
        nxt();
        req_ready = 1'b1;
        mid();
        nxt();
        mid();
        check_eq("rstt_rd_addr", req_addr, 32'h600);
        check_eq("rstt_rd_we", req_we, 1'b0);
        nxt();
        req_ready = 1'b0;
        mid();
        check_eq("rstt_wait_valid", req_valid, 1'b0);
        #1;
        rst_n = 1'b0; load_en = 1'b0;
        wr_q.delete(); ld_q.delete();
        #1;
        check_eq("rstt_req_valid", req_valid, 1'b0);
        check_eq("rstt_stall0", stall, 1'b0);
        check_eq("rstt_ldata", l_data, 32'd0);
        nxt();
        nxt();
        rst_n = 1'b1;
        rsp_valid = 1'b1; rsp_rdata = 32'hBAD0BAD0;
        mid();
        check_eq("stray_rsp_stall", stall, 1'b0);
        check_eq("stray_rsp_valid", req_valid, 1'b0);
        nxt();
        rsp_valid = 1'b0;
        mid();
        check_eq("rst_no_drain", req_valid, 1'b0);
        nxt();
        load_en = 1'b1; l_addr = 32'h500; ld_q.push_back(32'h99);
        mid();
        check_eq("post_rst_miss", stall, 1'b1);
        nxt();
        req_ready = 1'b1;
        mid();
        check_eq("post_rst_addr", req_addr, 32'h500);
        check_eq("post_rst_we", req_we, 1'b0);
        nxt();
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'h99;
        mid();
        check_eq("post_rst_done", stall, 1'b0);
        nxt();
        rsp_valid = 1'b0; load_en = 1'b0;
        nxt();
        check_eq("ld_q_empty", 32'(ld_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
